hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard_if.sv | 25 ++
 rtl/hazard_scoreboard.sv | 187 ++++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
// Decode/issue-side bundle between the issue stage and the hazard scoreboard.
// The issue stage drives the instruction and flush; the scoreboard returns forwarding selects and stall.
interface hazard_scoreboard_if #(
  parameter int NSTAGES = 3
);
  localparam int SEL_W = $clog2(NSTAGES + 1);

  logic             issue_valid;
  logic [31:0]      instruction_s1;
  logic             flush;
  logic [SEL_W-1:0] fwd_sel_1;
  logic [SEL_W-1:0] fwd_sel_2;
  logic             stall;
  logic [31:0]      stall_cnt;

  modport master (
    output issue_valid, instruction_s1, flush,
    input  fwd_sel_1, fwd_sel_2, stall, stall_cnt
  );

  modport slave (
    input  issue_valid, instruction_s1, flush,
    output fwd_sel_1, fwd_sel_2, stall, stall_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// RAW hazard scoreboard: shift chain of older writers, youngest-match forwarding select,
// load-use (or no-forwarding) stall request and a free-running stall-cycle counter.
module hazard_scoreboard #(
  parameter int NSTAGES  = 3,
  parameter int LOAD_LAT = 2,
  parameter int FWD_EN   = 1
) (
  input  logic              clk,
  input  logic              rst,
  hazard_scoreboard_if.slave bus
);
  localparam int SEL_W = $clog2(NSTAGES + 1);

  localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;
  localparam logic [6:0] OPC_ARI_ITYPE = 7'b0010011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_CSR       = 7'b1110011;

  logic [6:0] opcode;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [4:0] dec_rd;
  logic       dec_writer;
  logic       dec_is_load;
  logic       use_rs1;
  logic       use_rs2;
  logic       unused_bits;

  assign opcode      = bus.instruction_s1[6:0];
  assign dec_rd      = bus.instruction_s1[11:7];
  assign rs1         = bus.instruction_s1[19:15];
  assign rs2         = bus.instruction_s1[24:20];
  assign unused_bits = ^{bus.instruction_s1[31:25], bus.instruction_s1[14:12]};

  always_comb begin
    dec_writer  = 1'b0;
    dec_is_load = 1'b0;
    use_rs1     = 1'b0;
    use_rs2     = 1'b0;
    case (opcode)
      OPC_ARI_RTYPE: begin dec_writer = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OPC_ARI_ITYPE: begin dec_writer = 1'b1; use_rs1 = 1'b1; end
      OPC_LOAD:      begin dec_writer = 1'b1; use_rs1 = 1'b1; dec_is_load = 1'b1; end
      OPC_STORE:     begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OPC_BRANCH:    begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OPC_AUIPC,
      OPC_LUI,
      OPC_JAL:       dec_writer = 1'b1;
      OPC_JALR,
      OPC_CSR:       begin dec_writer = 1'b1; use_rs1 = 1'b1; end
      default:       dec_writer = 1'b0;
    endcase
  end

  // Flattened view of the chain; bit/element k-1 is entry k (k positions ahead).
  logic [NSTAGES-1:0]      ent_valid;
  logic [NSTAGES-1:0][4:0] ent_rd;
  logic [NSTAGES-1:0]      ent_is_load;

  logic       stall;
  logic       new_valid;
  logic [4:0] new_rd;
  logic       new_is_load;

  // x0 is never a real destination, so it is stored as a bubble and can never match.
  assign new_valid   = bus.issue_valid & ~stall & ~bus.flush & dec_writer & (dec_rd != 5'd0);
  assign new_rd      = dec_rd;
  assign new_is_load = dec_is_load;

  genvar gi;
  generate
    for (gi = 0; gi < NSTAGES; gi++) begin : g_stage
      logic       valid_q;
      logic       valid_d;
      logic [4:0] rd_q;
      logic [4:0] rd_d;
      logic       is_load_q;
      logic       is_load_d;

      if (gi == 0) begin : g_head
        always_comb begin
          valid_d   = new_valid;
          rd_d      = new_rd;
          is_load_d = new_is_load;
        end
      end else begin : g_tail
        always_comb begin
          valid_d   = ent_valid[gi-1];
          rd_d      = ent_rd[gi-1];
          is_load_d = ent_is_load[gi-1];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          valid_q   <= 1'b0;
          rd_q      <= 5'd0;
          is_load_q <= 1'b0;
        end else begin
          valid_q   <= valid_d;
          rd_q      <= rd_d;
          is_load_q <= is_load_d;
        end
      end

      assign ent_valid[gi]   = valid_q;
      assign ent_rd[gi]      = rd_q;
      assign ent_is_load[gi] = is_load_q;
    end
  endgenerate

  // Returns {stall_request, select}; scanning oldest-to-youngest lets the youngest match win.
  function automatic logic [SEL_W:0] resolve(
    input logic                    used,
    input logic [4:0]              rs,
    input logic [NSTAGES-1:0]      v,
    input logic [NSTAGES-1:0][4:0] rd,
    input logic [NSTAGES-1:0]      ld
  );
    logic             hit;
    int               hk;
    logic             hl;
    logic             req;
    logic [SEL_W-1:0] sel;
    hit = 1'b0;
    hk  = 0;
    hl  = 1'b0;
    req = 1'b0;
    sel = '0;
    for (int k = NSTAGES - 1; k >= 0; k--) begin
      if (v[k] && (rd[k] == rs)) begin
        hit = 1'b1;
        hk  = k + 1;
        hl  = ld[k];
      end
    end
    if (used && hit) begin
      if (FWD_EN == 0) begin
        req = 1'b1;
      end else if (hl && (hk < LOAD_LAT)) begin
        req = 1'b1;
      end else begin
        sel = SEL_W'(hk);
      end
    end
    return {req, sel};
  endfunction

  logic [SEL_W:0] res_1;
  logic [SEL_W:0] res_2;

  always_comb begin
    res_1 = resolve(bus.issue_valid & use_rs1, rs1, ent_valid, ent_rd, ent_is_load);
    res_2 = resolve(bus.issue_valid & use_rs2, rs2, ent_valid, ent_rd, ent_is_load);
  end

  assign stall         = (res_1[SEL_W] | res_2[SEL_W]) & ~bus.flush;
  assign bus.fwd_sel_1 = res_1[SEL_W-1:0];
  assign bus.fwd_sel_2 = res_2[SEL_W-1:0];
  assign bus.stall     = stall;

  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: forwarding DUT (FWD_EN=1) and non-forwarding DUT (FWD_EN=0).
module tb_hazard_scoreboard;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  hazard_scoreboard_if #(.NSTAGES(3)) bus_a ();
  hazard_scoreboard_if #(.NSTAGES(3)) bus_b ();

  hazard_scoreboard #(.NSTAGES(3), .LOAD_LAT(2), .FWD_EN(1)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a.slave)
  );
  hazard_scoreboard #(.NSTAGES(3), .LOAD_LAT(2), .FWD_EN(0)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2);
    return {7'd0, r2, r1, 3'b000, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] itype(input logic [4:0] rd, input logic [4:0] r1, input logic [11:0] imm);
    return {imm, r1, 3'b000, rd, 7'b0010011};
  endfunction
  function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] r1, input logic [11:0] imm);
    return {imm, r1, 3'b010, rd, 7'b0000011};
  endfunction
  function automatic logic [31:0] sw(input logic [4:0] r2, input logic [4:0] r1, input logic [11:0] imm);
    return {imm[11:5], r2, r1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  task automatic set_a(input logic v, input logic [31:0] ins, input logic fl);
    bus_a.issue_valid    = v;
    bus_a.instruction_s1 = ins;
    bus_a.flush          = fl;
    #2;
    $display("[%0t] A v=%0b ins=%08h fl=%0b rst=%0b -> sel1=%0d sel2=%0d stall=%0b cnt=%0d",
             $time, v, ins, fl, rst, bus_a.fwd_sel_1, bus_a.fwd_sel_2, bus_a.stall, bus_a.stall_cnt);
  endtask

  task automatic set_b(input logic v, input logic [31:0] ins, input logic fl);
    bus_b.issue_valid    = v;
    bus_b.instruction_s1 = ins;
    bus_b.flush          = fl;
    #2;
    $display("[%0t] B v=%0b ins=%08h fl=%0b rst=%0b -> sel1=%0d sel2=%0d stall=%0b cnt=%0d",
             $time, v, ins, fl, rst, bus_b.fwd_sel_1, bus_b.fwd_sel_2, bus_b.stall, bus_b.stall_cnt);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus_a.issue_valid = 1'b0; bus_a.flush = 1'b0; bus_a.instruction_s1 = 32'd0;
    bus_b.issue_valid = 1'b0; bus_b.flush = 1'b0; bus_b.instruction_s1 = 32'd0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    set_a(1'b1, rtype(5'd6, 5'd5, 5'd5), 1'b0);
    checks++;
    if ({bus_a.fwd_sel_1, bus_a.fwd_sel_2, bus_a.stall} !== 5'b00000 || bus_a.stall_cnt !== 32'd0) begin
      failures++;
      $display("FAIL reset_initial: sel1=%0d sel2=%0d stall=%0b cnt=%0d, expected 0 0 0 0",
               bus_a.fwd_sel_1, bus_a.fwd_sel_2, bus_a.stall, bus_a.stall_cnt);
    end
    set_a(1'b1, rtype(5'd5, 5'd1, 5'd2), 1'b0);
    tick();
    do_reset();
    set_a(1'b1, rtype(5'd6, 5'd5, 5'd5), 1'b0);
    checks++;
    if ({bus_a.fwd_sel_1, bus_a.fwd_sel_2, bus_a.stall} !== 5'b00000) begin
      failures++;
      $display("FAIL reset_clears_chain: sel1=%0d sel2=%0d stall=%0b, expected 0 0 0",
               bus_a.fwd_sel_1, bus_a.fwd_sel_2, bus_a.stall);
    end
  endtask

  task automatic test_fwd_alu();
    do_reset();
    set_a(1'b1, rtype(5'd5, 5'd1, 5'd2), 1'b0);
    tick();
    set_a(1'b1, rtype(5'd6, 5'd5, 5'd3), 1'b0);
    checks++;
    if ({bus_a.fwd_sel_1, bus_a.fwd_sel_2, bus_a.stall} !== {2'd1, 2'd0, 1'b0}) begin
      failures++;
      $display("FAIL fwd_alu_k1: sel1=%0d sel2=%0d stall=%0b, expected 1 0 0",
               bus_a.fwd_sel_1, bus_a.fwd_sel_2, bus_a.stall);
    end
  endtask

  task automatic test_fwd_store();
    do_reset();
    set_a(1'b1, rtype(5'd5, 5'd1, 5'd2), 1'b0);
    tick();
    set_a(1'b1, itype(5'd0, 5'd0, 12'd0), 1'b0);
    tick();
    set_a(1'b1, sw(5'd5, 5'd1, 12'd0), 1'b0);
    checks++;
    if ({bus_a.fwd_sel_1, bus_a.fwd_sel_2, bus_a.stall} !== {2'd0, 2'd2, 1'b0}) begin
      failures++;
      $display("FAIL fwd_store_k2: sel1=%0d sel2=%0d stall=%0b, expected 0 2 0",
               bus_a.fwd_sel_1, bus_a.fwd_sel_2, bus_a.stall);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    set_a(1'b1, lw(5'd5, 5'd1, 12'd0), 1'b0);
    tick();
    set_a(1'b1, rtype(5'd6, 5'd5, 5'd5), 1'b0);
    checks++;
    if ({bus_a.fwd_sel_1, bus_a.fwd_sel_2, bus_a.stall} !== {2'd0, 2'd0, 1'b1} || bus_a.stall_cnt !== 32'd0) begin
      failures++;
      $display("FAIL load_use_stall: sel1=%0d sel2=%0d stall=%0b cnt=%0d, expected 0 0 1 0",
               bus_a.fwd_sel_1, bus_a.fwd_sel_2, bus_a.stall, bus_a.stall_cnt);
    end
    tick();
    set_a(1'b1, rtype(5'd6, 5'd5, 5'd5), 1'b0);
    checks++;
    if ({bus_a.fwd_sel_1, bus_a.fwd_sel_2, bus_a.stall} !== {2'd2, 2'd2, 1'b0} || bus_a.stall_cnt !== 32'd1) begin
      failures++;
      $display("FAIL load_use_release: sel1=%0d sel2=%0d stall=%0b cnt=%0d, expected 2 2 0 1",
               bus_a.fwd_sel_1, bus_a.fwd_sel_2, bus_a.stall, bus_a.stall_cnt);
    end
    tick();
    set_a(1'b0, 32'd0, 1'b0);
    checks++;
    if (bus_a.stall_cnt !== 32'd1) begin
      failures++;
      $display("FAIL load_use_cnt_hold: cnt=%0d, expected 1", bus_a.stall_cnt);
    end
  endtask

  task automatic test_youngest();
    do_reset();
    set_a(1'b1, itype(5'd5, 5'd0, 12'd1), 1'b0);
    tick();
    set_a(1'b1, itype(5'd5, 5'd0, 12'd2), 1'b0);
    tick();
    set_a(1'b1, rtype(5'd7, 5'd5, 5'd0), 1'b0);
    checks++;
    if ({bus_a.fwd_sel_1, bus_a.fwd_sel_2, bus_a.stall} !== {2'd1, 2'd0, 1'b0}) begin
      failures++;
      $display("FAIL youngest_wins: sel1=%0d sel2=%0d stall=%0b, expected 1 0 0",
               bus_a.fwd_sel_1, bus_a.fwd_sel_2, bus_a.stall);
    end
    tick();
    set_a(1'b1, itype(5'd0, 5'd0, 12'd1), 1'b0);
    tick();
    set_a(1'b1, rtype(5'd6, 5'd0, 5'd0), 1'b0);
    checks++;
    if ({bus_a.fwd_sel_1, bus_a.fwd_sel_2, bus_a.stall} !== 5'b00000) begin
      failures++;
      $display("FAIL x0_never_forwards: sel1=%0d sel2=%0d stall=%0b, expected 0 0 0",
               bus_a.fwd_sel_1, bus_a.fwd_sel_2, bus_a.stall);
    end
  endtask

  task automatic test_unused_sources();
    logic [31:0] lui_ins;
    lui_ins = {12'd0, 5'd5, 3'b000, 5'd8, 7'b0110111};
    do_reset();
    set_a(1'b1, itype(5'd5, 5'd0, 12'd1), 1'b0);
    tick();
    set_a(1'b1, itype(5'd6, 5'd5, 12'd5), 1'b0);
    checks++;
    if ({bus_a.fwd_sel_1, bus_a.fwd_sel_2, bus_a.stall} !== {2'd1, 2'd0, 1'b0}) begin
      failures++;
      $display("FAIL itype_rs2_unused: sel1=%0d sel2=%0d stall=%0b, expected 1 0 0",
               bus_a.fwd_sel_1, bus_a.fwd_sel_2, bus_a.stall);
    end
    set_a(1'b0, rtype(5'd6, 5'd5, 5'd5), 1'b0);
    checks++;
    if ({bus_a.fwd_sel_1, bus_a.fwd_sel_2, bus_a.stall} !== 5'b00000) begin
      failures++;
      $display("FAIL issue_invalid: sel1=%0d sel2=%0d stall=%0b, expected 0 0 0",
               bus_a.fwd_sel_1, bus_a.fwd_sel_2, bus_a.stall);
    end
    set_a(1'b1, lui_ins, 1'b0);
    checks++;
    if ({bus_a.fwd_sel_1, bus_a.fwd_sel_2, bus_a.stall} !== 5'b00000) begin
      failures++;
      $display("FAIL lui_no_sources: sel1=%0d sel2=%0d stall=%0b, expected 0 0 0",
               bus_a.fwd_sel_1, bus_a.fwd_sel_2, bus_a.stall);
    end
    tick();
    set_a(1'b1, sw(5'd1, 5'd2, 12'd5), 1'b0);
    tick();
    set_a(1'b1, rtype(5'd6, 5'd5, 5'd8), 1'b0);
    checks++;
    if ({bus_a.fwd_sel_1, bus_a.fwd_sel_2, bus_a.stall} !== {2'd3, 2'd2, 1'b0}) begin
      failures++;
      $display("FAIL store_not_writer: sel1=%0d sel2=%0d stall=%0b, expected 3 2 0",
               bus_a.fwd_sel_1, bus_a.fwd_sel_2, bus_a.stall);
    end
  endtask

  task automatic test_flush();
    do_reset();
    set_a(1'b1, lw(5'd5, 5'd1, 12'd0), 1'b0);
    tick();
    set_a(1'b1, rtype(5'd5, 5'd5, 5'd5), 1'b1);
    checks++;
    if (bus_a.stall !== 1'b0) begin
      failures++;
      $display("FAIL flush_beats_stall: stall=%0b, expected 0", bus_a.stall);
    end
    tick();
    set_a(1'b1, rtype(5'd7, 5'd5, 5'd0), 1'b0);
    checks++;
    if ({bus_a.fwd_sel_1, bus_a.fwd_sel_2, bus_a.stall} !== {2'd2, 2'd0, 1'b0} || bus_a.stall_cnt !== 32'd0) begin
      failures++;
      $display("FAIL flush_bubble: sel1=%0d sel2=%0d stall=%0b cnt=%0d, expected 2 0 0 0",
               bus_a.fwd_sel_1, bus_a.fwd_sel_2, bus_a.stall, bus_a.stall_cnt);
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    set_a(1'b1, lw(5'd5, 5'd1, 12'd0), 1'b0);
    tick();
    set_a(1'b1, rtype(5'd6, 5'd5, 5'd5), 1'b0);
    checks++;
    if (bus_a.stall !== 1'b1) begin
      failures++;
      $display("FAIL mid_stall_pre: stall=%0b, expected 1", bus_a.stall);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_a(1'b1, rtype(5'd6, 5'd5, 5'd5), 1'b0);
    checks++;
    if ({bus_a.fwd_sel_1, bus_a.fwd_sel_2, bus_a.stall} !== 5'b00000 || bus_a.stall_cnt !== 32'd0) begin
      failures++;
      $display("FAIL mid_stall_reset: sel1=%0d sel2=%0d stall=%0b cnt=%0d, expected 0 0 0 0",
               bus_a.fwd_sel_1, bus_a.fwd_sel_2, bus_a.stall, bus_a.stall_cnt);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_a(1'b1, lw(5'd5, 5'd1, 12'd0), 1'b0);
    tick();
    set_a(1'b1, rtype(5'd6, 5'd5, 5'd0), 1'b0);
    tick();
    set_a(1'b1, rtype(5'd6, 5'd5, 5'd0), 1'b0);
    checks++;
    if ({bus_a.fwd_sel_1, bus_a.fwd_sel_2, bus_a.stall} !== {2'd2, 2'd0, 1'b0}) begin
      failures++;
      $display("FAIL b2b_load_k2: sel1=%0d sel2=%0d stall=%0b, expected 2 0 0",
               bus_a.fwd_sel_1, bus_a.fwd_sel_2, bus_a.stall);
    end
    tick();
    set_a(1'b1, rtype(5'd7, 5'd6, 5'd5), 1'b0);
    checks++;
    if ({bus_a.fwd_sel_1, bus_a.fwd_sel_2, bus_a.stall} !== {2'd1, 2'd3, 1'b0} || bus_a.stall_cnt !== 32'd1) begin
      failures++;
      $display("FAIL b2b_mixed: sel1=%0d sel2=%0d stall=%0b cnt=%0d, expected 1 3 0 1",
               bus_a.fwd_sel_1, bus_a.fwd_sel_2, bus_a.stall, bus_a.stall_cnt);
    end
  endtask

  task automatic test_no_forwarding();
    do_reset();
    set_b(1'b1, rtype(5'd5, 5'd1, 5'd2), 1'b0);
    tick();
    for (int c = 0; c < 3; c++) begin
      set_b(1'b1, rtype(5'd6, 5'd5, 5'd1), 1'b0);
      checks++;
      if ({bus_b.fwd_sel_1, bus_b.fwd_sel_2, bus_b.stall} !== {2'd0, 2'd0, 1'b1}) begin
        failures++;
        $display("FAIL nofwd_stall c%0d: sel1=%0d sel2=%0d stall=%0b, expected 0 0 1",
                 c, bus_b.fwd_sel_1, bus_b.fwd_sel_2, bus_b.stall);
      end
      tick();
    end
    set_b(1'b1, rtype(5'd6, 5'd5, 5'd1), 1'b0);
    checks++;
    if ({bus_b.fwd_sel_1, bus_b.fwd_sel_2, bus_b.stall} !== 5'b00000 || bus_b.stall_cnt !== 32'd3) begin
      failures++;
      $display("FAIL nofwd_release: sel1=%0d sel2=%0d stall=%0b cnt=%0d, expected 0 0 0 3",
               bus_b.fwd_sel_1, bus_b.fwd_sel_2, bus_b.stall, bus_b.stall_cnt);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus_a.issue_valid = 1'b0; bus_a.flush = 1'b0; bus_a.instruction_s1 = 32'd0;
    bus_b.issue_valid = 1'b0; bus_b.flush = 1'b0; bus_b.instruction_s1 = 32'd0;
    tick();
    test_reset();
    test_fwd_alu();
    test_fwd_store();
    test_load_use();
    test_youngest();
    test_unused_sources();
    test_flush();
    test_reset_mid_stall();
    test_back_to_back();
    test_no_forwarding();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded 100000 time units, expected completion");
    $fatal(1, "timeout");
  end
endmodule
